ksa_controller: RTL and testbench

Sequences the single-port 256×8 S-box memory through the full RC4 key-scheduling algorithm: the identity fill S[i]=i, then the 256-iteration swap loop with j = j + S[i] + key[i mod KEY_BYTES]. It is the sole master of the S-memory port while busy and hands a fully scheduled S array to the downstream PRGA/decrypt stage, signalled by a one-cycle `done` pulse.

---
 rtl/ksa_controller.sv | 136 +++++++++++++
 tb/tb_ksa_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ksa_controller.sv
// RC4 key-scheduling sequencer: identity-fills the 256x8 S-box, then runs the
// 256-step swap loop through a single-port memory with registered address.
module ksa_controller #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             s_address,
    output logic [7:0]             s_data,
    output logic                   s_wren,
    input  logic [7:0]             s_q
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, INIT, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, DONE
    } state_t;

    state_t state, state_d;

    logic [7:0]             i, j, si, sj;
    logic [KW-1:0]          k;
    logic [8*KEY_BYTES-1:0] key;
    logic [7:0]             key_byte;

    // Key byte 0 sits in the most significant byte.
    always_comb begin
        key_byte = key[8*(KEY_BYTES-1-int'(k)) +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d   = state;
        busy      = 1'b0;
        done      = 1'b0;
        s_address = 8'd0;
        s_data    = 8'd0;
        s_wren    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_d = INIT;
            end
            INIT: begin
                busy      = 1'b1;
                s_address = i;
                s_data    = i;
                s_wren    = 1'b1;
                if (i == 8'hFF) state_d = RD_I;
            end
            RD_I: begin
                busy      = 1'b1;
                s_address = i;
                state_d   = WT_I;
            end
            WT_I: begin
                busy      = 1'b1;
                s_address = i;
                state_d   = RD_J;
            end
            RD_J: begin
                busy      = 1'b1;
                s_address = j;
                state_d   = WT_J;
            end
            WT_J: begin
                busy      = 1'b1;
                s_address = j;
                state_d   = WR_I;
            end
            WR_I: begin
                busy      = 1'b1;
                s_address = i;
                s_data    = sj;
                s_wren    = 1'b1;
                state_d   = WR_J;
            end
            WR_J: begin
                busy      = 1'b1;
                s_address = j;
                s_data    = si;
                s_wren    = 1'b1;
                state_d   = (i == 8'hFF) ? DONE : RD_I;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i   <= 8'd0;
            j   <= 8'd0;
            k   <= '0;
            si  <= 8'd0;
            sj  <= 8'd0;
            key <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        key <= secret_key;
                        i   <= 8'd0;
                        j   <= 8'd0;
                        k   <= '0;
                    end
                end
                // i wraps 255 -> 0 on the last fill write, ready for the swap loop
                INIT: i <= i + 8'd1;
                WT_I: begin
                    si <= s_q;
                    j  <= j + s_q + key_byte;
                end
                WT_J: sj <= s_q;
                WR_J: begin
                    k <= (k == K_LAST) ? '0 : k + KW'(1);
                    if (i != 8'hFF) i <= i + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_controller.sv
// Bench for ksa_controller: behavioural S-memory, software RC4 KSA model,
// per-cycle bus checks, known-vector table and final S comparison.
module tb_ksa_controller;

    localparam int KB = 3;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [23:0] secret_key;
    logic        busy, done, s_wren;
    logic [7:0]  s_address, s_data, s_q;

    ksa_controller #(.KEY_BYTES(KB)) dut (
        .clk(clk), .reset(reset), .start(start),
        .secret_key(secret_key), .busy(busy), .done(done),
        .s_address(s_address), .s_data(s_data),
        .s_wren(s_wren), .s_q(s_q)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (s_wren) mem[s_address] <= s_data;
        s_q <= mem[s_address];
    end

    int tests = 0;
    int fails = 0;

    logic [7:0] ref_s [256];
    logic [7:0] ref_j [256];
    logic [7:0] ref_si [256];
    logic [7:0] ref_sj [256];
    logic [7:0] obs_ai [256];
    logic [7:0] obs_di [256];
    logic [7:0] obs_aj [256];
    logic [7:0] obs_dj [256];

    typedef struct {
        logic [23:0] key;
        int          m;
        logic [7:0]  ai, di, aj, dj;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] kb [KB];
        logic [7:0] t;
        int jj;
        for (int b = 0; b < KB; b++) kb[b] = key[23-8*b -: 8];
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        jj = 0;
        for (int n = 0; n < 256; n++) begin
            jj = (jj + int'(s[n]) + int'(kb[n % KB])) % 256;
            ref_j[n]  = 8'(jj);
            ref_si[n] = s[n];
            ref_sj[n] = s[jj];
            t = s[n]; s[n] = s[jj]; s[jj] = t;
        end
        for (int n = 0; n < 256; n++) ref_s[n] = s[n];
    endfunction

    // {busy, done, wren, addr, data}; mask clears don't-care fields
    function automatic logic [18:0] exp_vec(input int n, output logic [18:0] mask);
        int m, p;
        logic [18:0] e;
        e = '0;
        mask = 19'h7FFFF;
        if (n <= 256) begin
            e = {3'b101, 8'(n-1), 8'(n-1)};
        end else if (n <= 1792) begin
            m = (n - 257) / 6;
            p = (n - 257) % 6;
            case (p)
                0, 1: e = {3'b100, 8'(m), 8'd0};
                2, 3: e = {3'b100, ref_j[m], 8'd0};
                4:    e = {3'b101, 8'(m), ref_sj[m]};
                default: e = {3'b101, ref_j[m], ref_si[m]};
            endcase
            if (p < 4) mask = 19'h7FF00;
        end else begin
            e = (n == 1793) ? {3'b010, 16'd0} : 19'd0;
            mask = 19'h70000;
        end
        return e;
    endfunction

    // mode 0: plain run; 1: start/key churn while busy; 2: reset at cycle 900
    task automatic run(input logic [23:0] key, input int mode);
        logic [18:0] e, mask, a;
        int m, p;
        model(key);
        secret_key = key;
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 1794; n++) begin
            @(negedge clk);
            if (mode == 2 && n == 900) begin
                reset = 1'b1;
                start = 1'b0;
                for (int r = 0; r < 3; r++) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk($sformatf("reset_mid r%0d", r),
                        32'({busy, done, s_wren, s_address, s_data}), 32'd0);
                end
                reset = 1'b0;
                return;
            end
            e = exp_vec(n, mask);
            a = {busy, done, s_wren, s_address, s_data};
            chk($sformatf("bus key=%h cyc=%0d", key, n), 32'(a & mask), 32'(e & mask));
            if (n >= 257 && n <= 1792) begin
                m = (n - 257) / 6;
                p = (n - 257) % 6;
                if (p == 4) begin obs_ai[m] = s_address; obs_di[m] = s_data; end
                if (p == 5) begin obs_aj[m] = s_address; obs_dj[m] = s_data; end
            end
            if (mode == 1 && n < 1793) begin
                start = (n < 600) ? 1'b1 : 1'($urandom_range(0, 1));
                secret_key = 24'($urandom);
            end else begin
                start = 1'b0;
                secret_key = key;
            end
        end
        for (int n = 0; n < 256; n++)
            chk($sformatf("S[%0d] key=%h", n, key), 32'(mem[n]), 32'(ref_s[n]));
    endtask

    task automatic check_tbl(input logic [23:0] key);
        for (int t = 0; t < 5; t++) begin
            if (tbl[t].key == key) begin
                chk($sformatf("tbl%0d wri_addr", t), 32'(obs_ai[tbl[t].m]), 32'(tbl[t].ai));
                chk($sformatf("tbl%0d wri_data", t), 32'(obs_di[tbl[t].m]), 32'(tbl[t].di));
                chk($sformatf("tbl%0d wrj_addr", t), 32'(obs_aj[tbl[t].m]), 32'(tbl[t].aj));
                chk($sformatf("tbl%0d wrj_data", t), 32'(obs_dj[tbl[t].m]), 32'(tbl[t].dj));
            end
        end
    endtask

    initial begin
        tbl[0] = '{24'h000249, 0, 8'd0,  8'd0,   8'd0,   8'd0};
        tbl[1] = '{24'h000249, 1, 8'd1,  8'd3,   8'd3,   8'd1};
        tbl[2] = '{24'h000249, 2, 8'd2,  8'd78,  8'd78,  8'd2};
        tbl[3] = '{24'hFFFFFF, 0, 8'd0,  8'hFF,  8'hFF,  8'd0};
        tbl[4] = '{24'hFFFFFF, 1, 8'd1,  8'd0,   8'hFF,  8'd1};

        reset = 1'b1;
        start = 1'b0;
        secret_key = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'({busy, done, s_wren, s_address, s_data}), 32'd0);
        reset = 1'b0;

        run(24'h000000, 0);
        run(24'h000249, 0);
        check_tbl(24'h000249);
        run(24'hFFFFFF, 0);
        check_tbl(24'hFFFFFF);
        run(24'($urandom), 1);
        run(24'($urandom), 0);
        run(24'($urandom), 2);
        run(24'($urandom), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
